// File: rtl/vedic_mul_pipe.sv
// Pipelined unsigned NxN Vedic (Urdhva Tiryakbhyam) multiplier with a valid/ready handshake.
// Operand halves are cross-multiplied in S1 and the partial products are summed in S2.

module vedic_mul_core #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    localparam int unsigned H  = W / 2;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned MW = W + 1;

    if (W == 2) begin : g_base
        // 2x2 Vedic cell: four partial-product ANDs reduced by two half adders
        logic t0, t1, t2, t3, s1, c1, s2, c2;
        always_comb begin
            t0 = a[0] & b[0];
            t1 = a[1] & b[0];
            t2 = a[0] & b[1];
            t3 = a[1] & b[1];
            s1 = t1 ^ t2;
            c1 = t1 & t2;
            s2 = t3 ^ c1;
            c2 = t3 & c1;
            p  = {c2, s2, s1, t0};
        end
    end else begin : g_rec
        logic [W-1:0]  pll, plh, phl, phh;
        logic [MW-1:0] mid;

        vedic_mul_core #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(pll));
        vedic_mul_core #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(plh));
        vedic_mul_core #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(phl));
        vedic_mul_core #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(phh));

        always_comb begin
            mid = MW'(plh) + MW'(phl);
            p   = PW'(pll) + (PW'(mid) << H) + (PW'(phh) << W);
        end
    end
endmodule

module vedic_mul_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned SW = 2 * H;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned MW = SW + 1;

    if (!(WIDTH == 2 || WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
        $error("vedic_mul_pipe: WIDTH must be 2, 4, 8, 16 or 32");
    end

    logic [SW-1:0] pll_c, plh_c, phl_c, phh_c;

    if (WIDTH == 2) begin : g_w2
        // Half-width operands are single bits, so the sub-products are plain ANDs
        always_comb begin
            pll_c = {1'b0, a[0] & b[0]};
            plh_c = {1'b0, a[0] & b[1]};
            phl_c = {1'b0, a[1] & b[0]};
            phh_c = {1'b0, a[1] & b[1]};
        end
    end else begin : g_wn
        vedic_mul_core #(.W(H)) u_ll (.a(a[H-1:0]),     .b(b[H-1:0]),     .p(pll_c));
        vedic_mul_core #(.W(H)) u_lh (.a(a[H-1:0]),     .b(b[WIDTH-1:H]), .p(plh_c));
        vedic_mul_core #(.W(H)) u_hl (.a(a[WIDTH-1:H]), .b(b[H-1:0]),     .p(phl_c));
        vedic_mul_core #(.W(H)) u_hh (.a(a[WIDTH-1:H]), .b(b[WIDTH-1:H]), .p(phh_c));
    end

    logic          s1_valid_q, s1_valid_d;
    logic [SW-1:0] pll_q, pll_d, plh_q, plh_d, phl_q, phl_d, phh_q, phh_d;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_p_q, out_p_d;
    logic [MW-1:0] mid_c;
    logic          stall_c;

    // Whole pipe advances together; a held output freezes every stage
    always_comb begin
        stall_c     = out_valid_q && !out_ready;
        s1_valid_d  = s1_valid_q;
        pll_d       = pll_q;
        plh_d       = plh_q;
        phl_d       = phl_q;
        phh_d       = phh_q;
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        mid_c       = MW'(plh_q) + MW'(phl_q);
        if (!stall_c) begin
            s1_valid_d  = in_valid;
            pll_d       = pll_c;
            plh_d       = plh_c;
            phl_d       = phl_c;
            phh_d       = phh_c;
            out_valid_d = s1_valid_q;
            out_p_d     = PW'(pll_q) + (PW'(mid_c) << H) + (PW'(phh_q) << WIDTH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            pll_q       <= '0;
            plh_q       <= '0;
            phl_q       <= '0;
            phh_q       <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            pll_q       <= pll_d;
            plh_q       <= plh_d;
            phl_q       <= phl_d;
            phh_q       <= phh_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
        end
    end

    assign in_ready  = !stall_c;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Scoreboard bench for vedic_mul_pipe: WIDTH=8 handshake scenarios plus WIDTH=2/4/16 arithmetic sweeps.

module tb_vedic_mul_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [15:0] out_p;

    logic        v2, r2, ov2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;
    logic        v4, r4, ov4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        v16, r16, ov16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic        sweep_ready;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_q[$];
    logic [3:0]  q2[$];
    logic [7:0]  q4[$];
    logic [31:0] q16[$];

    always #5 clk = ~clk;

    vedic_mul_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p));
    vedic_mul_pipe #(.WIDTH(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(sweep_ready), .out_p(p2));
    vedic_mul_pipe #(.WIDTH(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(sweep_ready), .out_p(p4));
    vedic_mul_pipe #(.WIDTH(16)) dut_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(sweep_ready), .out_p(p16));

    task automatic test_reset;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        vectors++; if (out_p !== 16'h0) begin miscompares++; $display("FAIL reset_out_p: got %h exp 0000", out_p); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; a = 8'd5; b = 8'd6;
        @(posedge clk); #1;
        a = 8'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL preload_out_valid: got %b exp 1", out_valid); end
        #3 rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL async_out_valid: got %b exp 0", out_valid); end
        vectors++; if (out_p !== 16'h0) begin miscompares++; $display("FAIL async_out_p: got %h exp 0000", out_p); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL async_in_ready: got %b exp 1", in_ready); end
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle[%0d]: got %b exp 0", i, out_valid); end
        end
    endtask

    task automatic test_latency;
        @(posedge clk); #1;
        in_valid = 1'b1; a = 8'd255; b = 8'd255;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early: got %b exp 0", out_valid); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL latency_valid: got %b exp 1", out_valid); end
        vectors++; if (out_p !== 16'hFE01) begin miscompares++; $display("FAIL latency_value: got %h exp fe01", out_p); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_after: got %b exp 0", out_valid); end
    endtask

    task automatic test_stream;
        logic [15:0] e;
        int got = 0;
        exp_q.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 102; cyc++) begin
            @(posedge clk); #1;
            in_valid = (cyc < 100);
            a = 8'($urandom); b = 8'($urandom);
            #1;
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin miscompares++; $display("FAIL stream_extra: got %h exp none", out_p); end
                else begin
                    e = exp_q.pop_front();
                    if (out_p !== e) begin miscompares++; $display("FAIL stream_value[%0d]: got %h exp %h", got, out_p, e); end
                end
                got++;
            end
            if (cyc >= 2) begin
                vectors++;
                if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_gap[%0d]: got %b exp 1", cyc, out_valid); end
            end
            if (cyc < 100) begin
                vectors++;
                if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready[%0d]: got %b exp 1", cyc, in_ready); end
            end
            if (in_valid && in_ready) exp_q.push_back(16'(a) * 16'(b));
        end
        in_valid = 1'b0;
        vectors++; if (got != 100) begin miscompares++; $display("FAIL stream_count: got %0d exp 100", got); end
    endtask

    task automatic test_backpressure;
        logic [7:0]  ta[5] = '{8'd3, 8'd15, 8'd0, 8'd128, 8'd255};
        logic [7:0]  tb[5] = '{8'd7, 8'd15, 8'd200, 8'd2, 8'd1};
        logic [15:0] ex[5] = '{16'd21, 16'd225, 16'd0, 16'd256, 16'd255};
        logic [15:0] e;
        int idx = 0, got = 0, stalls = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(posedge clk); #1;
            if (out_valid && stalls < 4) begin out_ready = 1'b0; stalls++; end
            else out_ready = 1'b1;
            in_valid = (idx < 5);
            if (idx < 5) begin a = ta[idx]; b = tb[idx]; end
            #1;
            if (!out_ready) begin
                vectors++; if (out_p !== 16'd21) begin miscompares++; $display("FAIL bp_hold_value: got %0d exp 21", out_p); end
                vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b exp 0", in_ready); end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin miscompares++; $display("FAIL bp_extra: got %0d exp none", out_p); end
                else begin
                    e = exp_q.pop_front();
                    if (out_p !== e) begin miscompares++; $display("FAIL bp_value[%0d]: got %0d exp %0d", got, out_p, e); end
                end
                got++;
            end
            if (in_valid && in_ready) begin exp_q.push_back(ex[idx]); idx++; end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        vectors++; if (got != 5) begin miscompares++; $display("FAIL bp_count: got %0d exp 5", got); end
        vectors++; if (stalls != 4) begin miscompares++; $display("FAIL bp_stall_cycles: got %0d exp 4", stalls); end
    endtask

    task automatic test_bubbles;
        logic        vp[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] exv[4] = '{16'd256, 16'd0, 16'd289, 16'd0};
        logic [15:0] e;
        exp_q.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #1;
            in_valid = (cyc < 4) ? vp[cyc] : 1'b0;
            a = (cyc < 2) ? 8'd16 : 8'd17;
            b = a;
            #1;
            if (cyc >= 2) begin
                vectors++;
                if (out_valid !== vp[cyc-2]) begin miscompares++; $display("FAIL bubble_valid[%0d]: got %b exp %b", cyc, out_valid, vp[cyc-2]); end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin miscompares++; $display("FAIL bubble_extra: got %0d exp none", out_p); end
                else begin
                    e = exp_q.pop_front();
                    if (out_p !== e) begin miscompares++; $display("FAIL bubble_value: got %0d exp %0d", out_p, e); end
                end
            end
            if (in_valid && in_ready && cyc < 4) exp_q.push_back(exv[cyc]);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_width_sweep;
        int got4 = 0;
        logic [3:0]  e2;
        logic [7:0]  e4;
        logic [31:0] e16;
        for (int cyc = 0; cyc < 260; cyc++) begin
            @(posedge clk); #1;
            v2  = (cyc == 0); a2 = 2'd3; b2 = 2'd3;
            v16 = (cyc == 0); a16 = 16'hFFFF; b16 = 16'hFFFF;
            v4  = (cyc < 256); a4 = 4'(cyc >> 4); b4 = 4'(cyc);
            #1;
            if (ov2) begin
                vectors++;
                if (q2.size() == 0) begin miscompares++; $display("FAIL w2_extra: got %b exp none", p2); end
                else begin e2 = q2.pop_front(); if (p2 !== e2) begin miscompares++; $display("FAIL w2_value: got %b exp %b", p2, e2); end end
            end
            if (ov16) begin
                vectors++;
                if (q16.size() == 0) begin miscompares++; $display("FAIL w16_extra: got %h exp none", p16); end
                else begin e16 = q16.pop_front(); if (p16 !== e16) begin miscompares++; $display("FAIL w16_value: got %h exp %h", p16, e16); end end
            end
            if (ov4) begin
                vectors++;
                if (q4.size() == 0) begin miscompares++; $display("FAIL w4_extra: got %0d exp none", p4); end
                else begin e4 = q4.pop_front(); if (p4 !== e4) begin miscompares++; $display("FAIL w4_value[%0d]: got %0d exp %0d", got4, p4, e4); end end
                got4++;
            end
            if (v2 && r2) q2.push_back(4'd9);
            if (v16 && r16) q16.push_back(32'hFFFE0001);
            if (v4 && r4) q4.push_back(8'(a4) * 8'(b4));
        end
        v2 = 1'b0; v4 = 1'b0; v16 = 1'b0;
        vectors++; if (got4 != 256) begin miscompares++; $display("FAIL w4_count: got %0d exp 256", got4); end
        vectors++; if (q2.size() != 0 || q16.size() != 0) begin miscompares++; $display("FAIL sweep_leftover: got %0d exp 0", q2.size() + q16.size()); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        v2 = 1'b0; a2 = '0; b2 = '0; v4 = 1'b0; a4 = '0; b4 = '0;
        v16 = 1'b0; a16 = '0; b16 = '0; sweep_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_latency;
        test_stream;
        test_backpressure;
        test_bubbles;
        test_width_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vedic_mul_pipe.md
Name: vedic_mul_pipe

Overview:
Parametrised, pipelined unsigned NxN Vedic (Urdhva Tiryakbhyam) multiplier. It generalises the 2x2 Vedic cell to any power-of-two width through recursive decomposition. It adds a two-stage register pipeline with a valid/ready handshake, so it can sit in streaming datapaths (MAC and filter blocks) at one product per cycle with backpressure.

Parameters:
WIDTH, 8, operand width in bits; legal values 2, 4, 8, 16, 32. Any other value is an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a/b present this cycle
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  multiplicand, unsigned
b  input  WIDTH  multiplier, unsigned
out_valid  output  1  out_p holds a valid product
out_ready  input  1  downstream accepts out_p this cycle
out_p  output  2*WIDTH  product a*b, unsigned, full width

Behaviour:
- Reset: asserting rst_n low clears all stage valids and data regs immediately, regardless of clk. out_valid=0 and out_p=0. in_ready=1 once out_valid=0. Deassertion takes effect from the next rising edge. In-flight operands are discarded; no partial result appears after reset.
- Arithmetic: no `*` operator anywhere.
  - H=WIDTH/2. Split a={ah,al} and b={bh,bl}.
  - Four HxH sub-products are formed: pll=al*bl, plh=al*bh, phl=ah*bl, phh=ah*bh.
  - Sub-multipliers are built recursively down to 2x2 Vedic cells: 4 AND gates and 2 half adders.
  - For WIDTH=2, the base cell is used directly. Its sub-products are the single-bit ANDs.
- Stage S1, registered: on accept, latch pll, plh, phl and phh (each 2H bits) and set s1_valid.
- Stage S2, registered: form out_p = pll + ((plh+phl) << H) + (phh << WIDTH) at 2*WIDTH bits. No overflow is possible.
- Latency: exactly 2 clk edges from the accepting edge (in_valid && in_ready) to out_valid=1 with the matching out_p, when unstalled.
- Throughput: 1 product/cycle with out_ready held high.
- Handshake:
  - stall = out_valid && !out_ready.
  - in_ready = !stall, which is combinational from out_valid and out_ready.
  - When not stalled, S1 loads {in_valid, data} and S2 loads from S1 every edge. Bubbles propagate as valid=0.
  - When stalled, all stage regs hold. out_p and out_valid stay stable until the edge where out_ready=1.
  - The transfer point is an edge with out_valid && out_ready.
- Input rules:
  - a and b are sampled only on an accepting edge.
  - in_valid while in_ready=0 is ignored; upstream holds operands.
  - in_valid=0 inserts a bubble and never produces out_valid.
- Ordering: results leave in acceptance order. There are no drops and no duplicates.
- out_p while out_valid=0 is don't-care except after reset, where it is 0.
- Simultaneous events: on an edge with out_valid && out_ready && in_valid, the output is consumed and a new operand enters S1 on the same edge.
- Boundary: a=0 or b=0 gives 0. a=b=2^WIDTH-1 gives (2^WIDTH-1)^2, with the top bit pattern exercised.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with a valid operand in S1 and S2. Required: out_valid drops at once, out_p=0, in_ready=1. After release with in_valid=0, no out_valid for 5 cycles.
- Latency/values, WIDTH=8, out_ready=1: accept a=255,b=255 at edge t. Required: out_valid=1 with out_p=0xFE01 after edge t+2, then 0 at t+3 if no further input.
- Streaming: 100 back-to-back random pairs, out_ready=1. Required: 100 products in order, all matching the reference model, in_ready constantly 1, no gaps after the first 2 cycles.
- Backpressure: stream 5 pairs (3*7, 15*15, 0*200, 128*2, 255*1), out_ready=0 for 4 cycles after the first result. Required: out_p=21 held stable, in_ready=0 during the stall, then 21, 225, 0, 256, 255 delivered in order with none lost.
- Bubbles: in_valid pattern 1,0,1,0 with a=b=16,17. Required: out_valid pattern 1,0,1,0 two cycles later, out_p=256 then 289.
- Width sweep: WIDTH=2 with 3*3, giving 9 (4'b1001). WIDTH=16 with 65535*65535, giving 0xFFFE0001. Plus an exhaustive WIDTH=4 sweep (256 pairs) against the reference model.
